// File: rtl/pwm_pkg.sv
// Constants and state type shared by the PWM generator and decoder.
package pwm_pkg;
  localparam int PWM_PERIOD = 16;
  localparam int PWM_VAL_W  = 4;

  typedef enum logic {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } pwm_dec_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous line and flags its 0->1 transitions.
// Latency SYNC_STAGES clk to level; rise is a 1-cycle pulse in the first high cycle.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
endmodule

// File: rtl/pwm_decoder.sv
// Recovers PWM duty per period; val_valid SYNC_STAGES+1 clk after the pin rises, one-entry output overwritten (overrun) if not drained.
// Optional PWM_DECODER_ERRCNT_EN adds a saturating err_count output.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int VAL_W       = PWM_VAL_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [VAL_W-1:0] val,
  output logic             val_valid,
  input  logic             val_ready,
  output logic             err_period,
  output logic             err_sat,
  output logic             overrun
`ifdef PWM_DECODER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);
  localparam int               PW       = $clog2(PERIOD) + 1;
  localparam logic [PW-1:0]    PERIOD_C = PW'(PERIOD);
  localparam logic [VAL_W-1:0] VAL_MAX  = '1;

  logic             level;
  logic             rise;
  pwm_dec_state_t   state;
  logic [PW-1:0]    period_cnt;
  logic [VAL_W-1:0] high_cnt;

  logic             timeout;
  logic             edge_smp;
  logic             new_smp;
  logic             hs;
  logic [VAL_W-1:0] smp_val;
  logic             smp_errp;
  logic             smp_errs;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (level),
    .rise  (rise)
  );

  // A rise exactly PERIOD cycles after the last restart is a normal period, not a timeout.
  assign timeout  = !rise && (period_cnt >= PERIOD_C);
  assign edge_smp = rise && (state == MEASURE);
  assign new_smp  = edge_smp || timeout;
  assign hs       = val_valid && val_ready;

  always_comb begin
    smp_val  = '0;
    smp_errp = 1'b0;
    smp_errs = 1'b0;
    if (edge_smp) begin
      smp_val  = high_cnt;
      smp_errp = (period_cnt != PERIOD_C);
    end else if (timeout && level) begin
      smp_val  = VAL_MAX;
      smp_errs = 1'b1;
    end
  end

  // The restart cycle belongs to the new period, so its level seeds high_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      if (rise) state <= MEASURE;
      if (rise || timeout) begin
        period_cnt <= PW'(1);
        high_cnt   <= VAL_W'(level);
      end else begin
        if (period_cnt != PERIOD_C) period_cnt <= period_cnt + PW'(1);
        if (level && (high_cnt != VAL_MAX)) high_cnt <= high_cnt + VAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val        <= '0;
      val_valid  <= 1'b0;
      err_period <= 1'b0;
      err_sat    <= 1'b0;
      overrun    <= 1'b0;
    end else if (new_smp) begin
      val        <= smp_val;
      val_valid  <= 1'b1;
      err_period <= smp_errp;
      err_sat    <= smp_errs;
      overrun    <= !hs && val_valid;
    end else if (hs) begin
      val_valid  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

`ifdef PWM_DECODER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (new_smp && (smp_errp || smp_errs) && (err_count != 8'hff)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: period-level reference model checked every cycle plus literal spot checks.
module tb_pwm_decoder;
  import pwm_pkg::*;

  localparam int PERIOD      = PWM_PERIOD;
  localparam int VAL_W       = PWM_VAL_W;
  localparam int SYNC_STAGES = 2;
  localparam int VMAX        = (1 << VAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic             val_ready;
  logic [VAL_W-1:0] val;
  logic             val_valid;
  logic             err_period;
  logic             err_sat;
  logic             overrun;
`ifdef PWM_DECODER_ERRCNT_EN
  logic [7:0]       err_count;
  logic [7:0]       m_ecnt = '0;
  int               ecnt_before;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_decoder #(.PERIOD(PERIOD), .VAL_W(VAL_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .val        (val),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .err_period (err_period),
    .err_sat    (err_sat),
    .overrun    (overrun)
`ifdef PWM_DECODER_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: the line as seen after the synchronizer delay, the list of levels
  // since the last restart, and the output register contents it implies.
  logic             pipe [SYNC_STAGES];
  logic             prev_l = 1'b0;
  int               cyc = 0;
  int               restart_cyc = 0;
  bit               hist[$];
  bit               measuring = 1'b0;
  logic [VAL_W-1:0] m_val = '0;
  logic             m_valid = 1'b0;
  logic             m_errp = 1'b0;
  logic             m_errs = 1'b0;
  logic             m_ovr = 1'b0;

  task automatic model_step();
    logic             l;
    logic             emit;
    logic             hs;
    logic [VAL_W-1:0] e_val;
    logic             e_errp;
    logic             e_errs;
    int               hi;
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) pipe[i] = 1'b0;
      prev_l = 1'b0; cyc = 0; restart_cyc = 0; measuring = 1'b0;
      hist.delete();
      m_val = '0; m_valid = 1'b0; m_errp = 1'b0; m_errs = 1'b0; m_ovr = 1'b0;
`ifdef PWM_DECODER_ERRCNT_EN
      m_ecnt = '0;
`endif
      return;
    end
    l = pipe[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = pwm_in;
    emit = 1'b0; e_val = '0; e_errp = 1'b0; e_errs = 1'b0;
    if (l && !prev_l) begin
      if (measuring) begin
        hi = 0;
        foreach (hist[i]) hi += int'(hist[i]);
        emit   = 1'b1;
        e_val  = VAL_W'((hi > VMAX) ? VMAX : hi);
        e_errp = ((cyc - restart_cyc) != PERIOD);
      end
      measuring = 1'b1;
      restart_cyc = cyc; hist.delete(); hist.push_back(l);
    end else if ((cyc - restart_cyc) >= PERIOD) begin
      emit   = 1'b1;
      e_val  = l ? VAL_W'(VMAX) : '0;
      e_errs = l;
      restart_cyc = cyc; hist.delete(); hist.push_back(l);
    end else begin
      hist.push_back(l);
    end
    prev_l = l;
    hs = m_valid && val_ready;
    if (emit) begin
      m_ovr = hs ? 1'b0 : (m_ovr || m_valid);
      m_val = e_val; m_errp = e_errp; m_errs = e_errs; m_valid = 1'b1;
`ifdef PWM_DECODER_ERRCNT_EN
      if ((e_errp || e_errs) && m_ecnt != 8'hff) m_ecnt = m_ecnt + 8'd1;
`endif
    end else if (hs) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
    cyc++;
  endtask

  function automatic logic [31:0] dut_vec();
`ifdef PWM_DECODER_ERRCNT_EN
    return 32'({err_count, overrun, err_sat, err_period, val_valid, val});
`else
    return 32'({overrun, err_sat, err_period, val_valid, val});
`endif
  endfunction

  function automatic logic [31:0] exp_vec();
`ifdef PWM_DECODER_ERRCNT_EN
    return 32'({m_ecnt, m_ovr, m_errs, m_errp, m_valid, m_val});
`else
    return 32'({m_ovr, m_errs, m_errp, m_valid, m_val});
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) check("reset_outputs", dut_vec(), 32'd0);
      else     check("cycle_vs_model", dut_vec(), exp_vec());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gen_custom(input int high, input int per, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        pwm_in = (i < high);
        tick(1);
      end
    end
  endtask

  task automatic gen(input int value, input int n);
    gen_custom(value, PERIOD, n);
  endtask

  initial begin
    bit found;
    bit quiet;
    rst = 1'b1; pwm_in = 1'b0; val_ready = 1'b1;
    tick(3);
    check("rst_valid", val_valid, 0);
    check("rst_val", val, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(2);

    // First rise only arms the decoder; the second closes a measured period.
    gen(5, 1);
    pwm_in = 1'b1;
    tick(1); check("lat_edge1_valid", val_valid, 0);
    tick(1); check("lat_edge2_valid", val_valid, 0);
    tick(1); check("lat_edge3_valid", val_valid, 1);
    check("first_val", val, 5);
    check("first_err_period", err_period, 0);
    tick(2); pwm_in = 1'b0; tick(11);
    gen(5, 4);
    check("steady_val5", val, 5);

    for (int v = 0; v <= VMAX; v++) begin
      gen(v, 3);
      if (v == 0 || v == 1 || v == VMAX) begin
        check($sformatf("sweep_val_%0d", v), val, v);
        check($sformatf("sweep_errp_%0d", v), err_period, 0);
      end
    end

    pwm_in = 1'b1;
    tick(40);
    check("stuck_high_val", val, VMAX);
    check("stuck_high_err_sat", err_sat, 1);

`ifdef PWM_DECODER_ERRCNT_EN
    ecnt_before = int'(err_count);
`endif
    gen_custom(4, 12, 4);
    check("short_period_val", val, 4);
    check("short_period_errp", err_period, 1);
`ifdef PWM_DECODER_ERRCNT_EN
    check("err_count_delta", int'(err_count) - ecnt_before, 3);
`endif

    val_ready = 1'b0;
    gen(5, 3);
    check("ovr_valid", val_valid, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_val_newest", val, 5);
    val_ready = 1'b1; tick(1); val_ready = 1'b0;
    check("ovr_hs_valid", val_valid, 0);
    check("ovr_hs_flag", overrun, 0);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (val_valid) found = 1'b1;
    end
    check("timeout_sample_seen", found, 1);
    tick(15);
    val_ready = 1'b1;
    tick(1);
    check("coinc_valid", val_valid, 1);
    check("coinc_overrun", overrun, 0);
    tick(1);
    check("coinc_drained", val_valid, 0);

    val_ready = 1'b0;
    gen(9, 2);
    pwm_in = 1'b1;
    tick(3);
    check("prereset_val", val, 9);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", val_valid, 0);
    check("async_rst_val", val, 0);
    check("async_rst_flags", {err_period, err_sat, overrun}, 0);
    tick(2);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pwm_in = (i < 3);
      tick(1);
      if (val_valid) quiet = 1'b0;
    end
    check("post_reset_no_sample", quiet, 1);
    pwm_in = 1'b1;
    tick(3);
    check("post_reset_valid", val_valid, 1);
    check("post_reset_val", val, 3);
    check("post_reset_errp", err_period, 1);

    val_ready = 1'b1;
    tick(2); pwm_in = 1'b0; tick(11);
    gen(7, 3);
    check("final_val7", val, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
